arb_rr_nm1s: RTL

- Round-robin arbiter sharing one MemSplit32-style slave port among NUM_M masters.
- Sits between the tile's masters (CPU instruction/data, debug, DMA) and a single shared slave such as RAM or an SFR block.
- Tracks outstanding reads in an in-order route FIFO so each slave response returns only to the master that issued the read.
- Holds a grant stable while the slave stalls.

---
 rtl/sigma_arb_pkg.sv | 39 +++
 rtl/arb_route_fifo.sv | 45 ++++
 rtl/arb_rr_nm1s.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sigma_arb_pkg.sv
// Shared types and helpers for the round-robin N-master / 1-slave arbiter.
package sigma_arb_pkg;

  localparam int MAX_M    = 4;
  localparam int MAX_ID_W = 2;

  // One master-side request, as seen on the shared slave port.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  // Result of a round-robin search.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] idx;
  } pick_t;

  // Returns the first set bit of req_vec, searching from ptr upward and
  // wrapping at num_m.
  function automatic pick_t rr_pick(input logic [MAX_M-1:0]    req_vec,
                                    input logic [MAX_ID_W-1:0] ptr,
                                    input int                  num_m);
    pick_t res;
    int    k;
    res = '0;
    for (int i = 0; i < MAX_M; i++) begin
      k = (int'(ptr) + i) % num_m;
      if (i < num_m && !res.valid && req_vec[k]) begin
        res.valid = 1'b1;
        res.idx   = MAX_ID_W'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_route_fifo.sv
// In-order route FIFO: remembers which master issued each outstanding read.
// Pointers carry one extra MSB so full and empty are distinguishable.
module arb_route_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage write.
  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update; a simultaneous push and pop leaves occupancy unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/arb_rr_nm1s.sv
// Round-robin arbiter sharing one MemSplit32-style slave among NUM_M masters.
// Grants stay locked while the slave stalls; read responses are routed back
// through an in-order route FIFO. Optional per-master accept counters are
// built when ARB_PERF_CNT_EN is defined.
module arb_rr_nm1s
  import sigma_arb_pkg::*;
#(
  parameter int NUM_M       = 2,
  parameter int ROUTE_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_M-1:0]     m_req_i,
  input  logic [NUM_M-1:0]     m_we_i,
  input  logic [NUM_M*32-1:0]  m_addr_i,
  input  logic [NUM_M*4-1:0]   m_be_i,
  input  logic [NUM_M*32-1:0]  m_wdata_i,
  output logic [NUM_M-1:0]     m_ack_o,
  output logic [NUM_M-1:0]     m_resp_o,
  output logic [NUM_M*32-1:0]  m_rdata_o,
  output logic                 s_req_o,
  output logic                 s_we_o,
  output logic [31:0]          s_addr_o,
  output logic [3:0]           s_be_o,
  output logic [31:0]          s_wdata_o,
  input  logic                 s_ack_i,
  input  logic                 s_resp_i,
  input  logic [31:0]          s_rdata_i,
  output logic                 resp_err_o
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic                 perf_clr_i,
  output logic [NUM_M*32-1:0]  perf_cnt_o
`endif
);

  localparam int ID_W = $clog2(NUM_M);

  logic [ID_W-1:0]  rr_ptr;
  logic             lock;
  logic [ID_W-1:0]  lock_id;

  logic             fifo_full;
  logic             fifo_empty;
  logic [ID_W-1:0]  fifo_head;

  logic [MAX_M-1:0] elig;
  pick_t            pick;
  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  nxt_ptr;
  mreq_t            sel;
  logic             accept;
  logic             push;
  logic             pop;

  // Eligibility: reads are held back while the route FIFO is full.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_M; k++) begin
      elig[k] = m_req_i[k] && (m_we_i[k] || !fifo_full);
    end
  end

  assign pick      = rr_pick(elig, MAX_ID_W'(rr_ptr), NUM_M);
  assign gnt_valid = !rst_i && (lock || pick.valid);
  assign gnt_id    = lock ? lock_id : ID_W'(pick.idx);
  assign nxt_ptr   = (int'(gnt_id) == NUM_M - 1) ? '0 : gnt_id + ID_W'(1);

  assign accept = gnt_valid && s_ack_i;
  assign push   = accept && !sel.we;
  assign pop    = !rst_i && s_resp_i && !fifo_empty;

  // Mux the granted master onto the slave port; idle port drives zeros.
  always_comb begin
    sel = '0;
    if (gnt_valid) begin
      sel.we    = m_we_i[gnt_id];
      sel.addr  = m_addr_i[gnt_id*32 +: 32];
      sel.be    = m_be_i[gnt_id*4 +: 4];
      sel.wdata = m_wdata_i[gnt_id*32 +: 32];
    end
  end

  assign s_req_o   = gnt_valid;
  assign s_we_o    = sel.we;
  assign s_addr_o  = sel.addr;
  assign s_be_o    = sel.be;
  assign s_wdata_o = sel.wdata;

  // Slave ack goes only to the granted master.
  always_comb begin
    m_ack_o = '0;
    if (accept) m_ack_o[gnt_id] = 1'b1;
  end

  // Route each read response to the master at the FIFO head, same cycle.
  always_comb begin
    m_resp_o  = '0;
    m_rdata_o = '0;
    if (pop) begin
      m_resp_o[fifo_head]            = 1'b1;
      m_rdata_o[fifo_head*32 +: 32]  = s_rdata_i;
    end
  end

  // Round-robin pointer, stall lock and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      lock_id    <= '0;
      resp_err_o <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= nxt_ptr;
        lock   <= 1'b0;
      end else if (gnt_valid) begin
        lock    <= 1'b1;
        lock_id <= gnt_id;
      end
      if (s_resp_i && fifo_empty) resp_err_o <= 1'b1;
    end
  end

  arb_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .W     (ID_W)
  ) u_route_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (gnt_id),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_cnt [NUM_M];

  // Saturating per-master accept counters with synchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_M; k++) perf_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_M; k++) begin
        if (perf_clr_i)                               perf_cnt[k] <= {31'd0, m_ack_o[k]};
        else if (m_ack_o[k] && perf_cnt[k] != '1)     perf_cnt[k] <= perf_cnt[k] + 32'd1;
      end
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    perf_cnt_o = '0;
    for (int k = 0; k < NUM_M; k++) perf_cnt_o[k*32 +: 32] = perf_cnt[k];
  end
`endif

endmodule
